addr_loader: RTL



---
 rtl/addr_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/addr_loader.sv
// Serial SRAM address front-end: shifts in a framed address from the AVR, checks its
// length, commits it to the address register, then post-increments on each access.
module addr_loader #(
  parameter int ADDR_WIDTH = 21,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  si,
  input  logic                  sreg_en,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  wrapped
);

  localparam int CNT_W = $clog2(ADDR_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(ADDR_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOADED
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    sreg_en_q;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    valid_d, err_d, wrapped_d, busy_d;
  logic                    commit;

  function automatic logic [ADDR_WIDTH-1:0] shift_in(input logic [ADDR_WIDTH-1:0] sh,
                                                     input logic b);
    if (MSB_FIRST) return {sh[ADDR_WIDTH-2:0], b};
    else           return {b, sh[ADDR_WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    count_d   = count_q;
    addr_d    = addr;
    valid_d   = addr_valid;
    err_d     = frame_err;
    wrapped_d = 1'b0;
    commit    = 1'b0;

    case (state_q)
      IDLE, LOADED: begin
        if (!sreg_en) begin
          state_d  = SHIFT;
          shadow_d = shift_in(shadow_q, si);
          count_d  = CNT_W'(1);
        end
      end
      SHIFT: begin
        if (!sreg_en) begin
          shadow_d = shift_in(shadow_q, si);
          if (count_q != CNT_SAT) count_d = count_q + CNT_W'(1);
        end else if (!sreg_en_q) begin
          count_d = '0;
          if (count_q == CNT_FULL) begin
            commit  = 1'b1;
            addr_d  = shadow_q;
            valid_d = 1'b1;
            err_d   = 1'b0;
            state_d = LOADED;
          end else begin
            err_d   = 1'b1;
            state_d = addr_valid ? LOADED : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The committed address stays live during a new frame; a commit on the same edge wins.
    if (inc && addr_valid && !commit) begin
      addr_d    = addr + ADDR_WIDTH'(1);
      wrapped_d = &addr;
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      count_q    <= '0;
      sreg_en_q  <= 1'b1;
      addr       <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      count_q    <= count_d;
      sreg_en_q  <= sreg_en;
      addr       <= addr_d;
      addr_valid <= valid_d;
      busy       <= busy_d;
      frame_err  <= err_d;
      wrapped    <= wrapped_d;
    end
  end

endmodule
